yas_packet_framer: RTL and testbench



---
 rtl/yas_router_pkg.sv | 20 ++
 rtl/yas_crc8_step.sv | 22 ++
 rtl/yas_packet_framer.sv | 162 ++++++++++++++++
 tb/tb_yas_packet_framer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yas_router_pkg.sv
// Shared types and constants for the router input link.
// Used by the framer and by the router's CRC checker.
package yas_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_CRC
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 6;
  localparam int HDR_LEN_MSB  = 5;
  localparam int HDR_LEN_LSB  = 0;

endpackage

// File: rtl/yas_crc8_step.sv
// One-byte CRC-8 update, MSB-first, no reflection.
// Purely combinational so both ends of the link can share it.
module yas_crc8_step
  import yas_router_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = (c << 1) ^ CRC8_POLY;
      else      c = c << 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/yas_packet_framer.sv
// Frames commands and payload into header/payload/CRC bytes
// on the router input link through a one-entry output register.
module yas_packet_framer
  import yas_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_addr,
  input  logic [DATA_SIZE-1:0]  cmd_len,
  input  logic                  cmd_crc_en,
  output logic                  cmd_ready,
  output logic                  cmd_err,
  input  logic [DATA_WIDTH-1:0] pld_data,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_in_req,
  input  logic                  data_in_ack,
  output logic                  pkt_done,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [DATA_SIZE-1:0]  remaining_q, remaining_d;
  logic                  crc_en_q, crc_en_d;
  logic [7:0]            crc_q, crc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;
  logic                  last_q, last_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  load_ok;
  logic                  cmd_acc;
  logic                  pld_acc;
  logic                  load;
  logic                  load_last;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] hdr;
  logic [7:0]            crc_src;
  logic [7:0]            crc_byte;
  logic [7:0]            crc_nxt;

  // Header and payload never update the CRC in the same cycle,
  // so one step unit is shared between IDLE and PLD.
  yas_crc8_step u_crc (
    .crc_in  (crc_src),
    .byte_in (crc_byte),
    .crc_out (crc_nxt)
  );

  always_comb begin
    hdr = '0;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = cmd_addr;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = cmd_len;
  end

  always_comb begin
    load_ok   = !req_q || data_in_ack;
    cmd_ready = !rst && (state_q == ST_IDLE) && load_ok;
    pld_ready = !rst && (state_q == ST_PLD) && load_ok
                && (remaining_q != '0);
    cmd_acc   = cmd_valid && cmd_ready;
    pld_acc   = pld_valid && pld_ready;
    crc_src   = (state_q == ST_IDLE) ? CRC8_INIT : crc_q;
    crc_byte  = (state_q == ST_IDLE) ? hdr : pld_data;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    crc_en_d    = crc_en_q;
    crc_d       = crc_q;
    cmd_err_d   = 1'b0;
    load        = 1'b0;
    load_last   = 1'b0;
    load_data   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          if (cmd_len == '0) begin
            cmd_err_d = 1'b1;
          end else begin
            load        = 1'b1;
            load_data   = hdr;
            remaining_d = cmd_len;
            crc_en_d    = cmd_crc_en;
            crc_d       = crc_nxt;
            state_d     = ST_PLD;
          end
        end
      end
      ST_PLD: begin
        if (pld_acc) begin
          load        = 1'b1;
          load_data   = pld_data;
          remaining_d = remaining_q - 1'b1;
          crc_d       = crc_nxt;
          if (remaining_q == DATA_SIZE'(1)) begin
            load_last = !crc_en_q;
            state_d   = crc_en_q ? ST_CRC : ST_IDLE;
          end
        end
      end
      ST_CRC: begin
        if (load_ok) begin
          load      = 1'b1;
          load_data = crc_q;
          load_last = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    req_d  = req_q;
    last_d = last_q;
    if (load) begin
      data_d = load_data;
      req_d  = 1'b1;
      last_d = load_last;
    end else if (data_in_ack) begin
      req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      crc_en_q    <= 1'b0;
      crc_q       <= CRC8_INIT;
      data_q      <= '0;
      req_q       <= 1'b0;
      last_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      crc_en_q    <= crc_en_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      req_q       <= req_d;
      last_q      <= last_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign data_in     = data_q;
  assign data_in_req = req_q;
  assign cmd_err     = cmd_err_q;
  assign pkt_done    = !rst && req_q && last_q && data_in_ack;
  assign busy        = (state_q != ST_IDLE) || req_q;

endmodule

// File: tb/tb_yas_packet_framer.sv
// Scoreboard bench for yas_packet_framer: directed cases
// plus randomized packets against a queue-based link model.
module tb_yas_packet_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic       cmd_crc_en = 1'b0;
  logic       cmd_ready;
  logic       cmd_err;
  logic [7:0] pld_data = '0;
  logic       pld_valid = 1'b0;
  logic       pld_ready;
  logic [7:0] data_in;
  logic       data_in_req;
  logic       data_in_ack = 1'b1;
  logic       pkt_done;
  logic       busy;

  yas_packet_framer #(.DATA_WIDTH(8), .DATA_SIZE(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_crc_en  (cmd_crc_en),
    .cmd_ready   (cmd_ready),
    .cmd_err     (cmd_err),
    .pld_data    (pld_data),
    .pld_valid   (pld_valid),
    .pld_ready   (pld_ready),
    .data_in     (data_in),
    .data_in_req (data_in_req),
    .data_in_ack (data_in_ack),
    .pkt_done    (pkt_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ack_mode = 0;
  int   acyc = 0;
  int   cyc = 0;
  int   hs_count = 0;
  int   done_count = 0;
  int   first_hs = 0;
  int   last_hs = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as the remainder of the augmented message mod x^8+x^2+x+1
  function automatic logic [7:0] crc_of(logic [7:0] m[$]);
    logic [8:0] r = '0;
    for (int i = 0; i < m.size() + 1; i++) begin
      for (int k = 7; k >= 0; k--) begin
        r = {r[7:0], (i < m.size()) ? m[i][k] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    acyc++;
    case (ack_mode)
      0:       data_in_ack = 1'b1;
      1:       data_in_ack = ($urandom_range(0, 3) != 0);
      2:       data_in_ack = ((acyc % 4) == 3);
      default: data_in_ack = 1'b0;
    endcase
  end

  initial begin : monitor
    exp_t       e;
    bit         prev_stall = 0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall req hold", {31'd0, data_in_req}, 1);
          chk("stall data hold", {24'd0, data_in},
              {24'd0, prev_data});
        end
        if (data_in_req && data_in_ack) begin
          if (hs_count == 0) first_hs = cyc;
          last_hs = cyc;
          hs_count++;
          if (pkt_done) done_count++;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected byte: got %0h expected none",
                     data_in);
          end else begin
            e = sb.pop_front();
            chk("link byte", {24'd0, data_in}, {24'd0, e.b});
            chk("pkt_done", {31'd0, pkt_done}, {31'd0, e.last});
          end
        end else if (pkt_done) begin
          chk("pkt_done idle", {31'd0, pkt_done}, 0);
        end
        prev_stall = data_in_req && !data_in_ack;
        prev_data  = data_in;
      end
    end
  end

  // Entered and left at a negedge so packets can run back-to-back.
  task automatic send_pkt(input logic [1:0] a, input int len,
                          input bit ce, input bit gaps,
                          input logic [7:0] fixed[$]);
    logic [7:0] msg[$];
    logic [7:0] pl[$];
    int         n;
    int         idx;
    for (int i = 0; i < len; i++)
      pl.push_back(fixed.size() > i ? fixed[i]
                                    : 8'($urandom_range(0, 255)));
    msg.push_back({a, 6'(len)});
    foreach (pl[i]) msg.push_back(pl[i]);
    if (ce) msg.push_back(crc_of(msg));
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = 6'(len);
    cmd_crc_en = ce;
    n = 0;
    forever begin
      #1;
      if (cmd_ready) break;
      @(negedge clk);
      n++;
      if (n > 1000) begin
        chk("cmd accept timeout", 1, 0);
        cmd_valid = 1'b0;
        return;
      end
    end
    foreach (msg[i])
      sb.push_back('{b: msg[i], last: (i == msg.size() - 1)});
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    n = 0;
    while (idx < len) begin
      pld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pld_data  = pl[idx];
      #1;
      if (pld_valid && pld_ready) idx++;
      @(negedge clk);
      n++;
      if (n > 2000) begin
        chk("payload timeout", 1, 0);
        break;
      end
    end
    pld_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || data_in_req) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain pending", sb.size(), 0);
  endtask

  initial begin : stim
    logic [7:0] p[$];
    logic [7:0] none[$];
    int         n;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    pld_valid = 1'b1;
    #1;
    chk("cmd_ready in rst", {31'd0, cmd_ready}, 0);
    chk("pld_ready in rst", {31'd0, pld_ready}, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    pld_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("rst data_in", {24'd0, data_in}, 0);
    chk("rst req", {31'd0, data_in_req}, 0);
    chk("rst cmd_err", {31'd0, cmd_err}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    @(negedge clk);

    p = '{8'hA1, 8'hB2, 8'hC3};
    done_count = 0;
    send_pkt(2'd2, 3, 1'b0, 1'b0, p);
    drain();
    chk("pkt1 done count", done_count, 1);

    p = '{8'h00};
    send_pkt(2'd1, 1, 1'b1, 1'b0, p);
    drain();

    ack_mode = 2;
    p = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(2'd2, 3, 1'b0, 1'b0, p);
    drain();
    ack_mode = 0;
    @(negedge clk);

    hs_count = 0;
    done_count = 0;
    send_pkt(2'd3, 2, 1'b0, 1'b0, none);
    send_pkt(2'd0, 2, 1'b0, 1'b0, none);
    drain();
    chk("b2b byte count", hs_count, 6);
    chk("b2b span", last_hs - first_hs, 5);
    chk("b2b done pulses", done_count, 2);

    cmd_valid = 1'b1;
    cmd_addr  = 2'd1;
    cmd_len   = 6'd0;
    #1;
    chk("len0 cmd_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2;
    chk("len0 cmd_err pulse", {31'd0, cmd_err}, 1);
    chk("len0 no req", {31'd0, data_in_req}, 0);
    @(negedge clk);
    #2;
    chk("len0 cmd_err clear", {31'd0, cmd_err}, 0);
    chk("len0 still no req", {31'd0, data_in_req}, 0);
    @(negedge clk);
    send_pkt(2'd2, 4, 1'b1, 1'b0, none);
    drain();

    cmd_valid  = 1'b1;
    cmd_addr   = 2'd3;
    cmd_len    = 6'd5;
    cmd_crc_en = 1'b0;
    sb.push_back('{b: 8'hC5, last: 1'b0});
    n = 0;
    while (n < 100) begin
      #1;
      if (cmd_ready) break;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    pld_valid = 1'b1;
    pld_data  = 8'h11;
    sb.push_back('{b: 8'h11, last: 1'b0});
    n = 0;
    while (n < 100) begin
      #1;
      if (pld_ready) break;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    pld_data = 8'h22;
    rst = 1'b1;
    #2;
    chk("mid rst cmd_ready", {31'd0, cmd_ready}, 0);
    chk("mid rst pld_ready", {31'd0, pld_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    pld_valid = 1'b0;
    #2;
    chk("post rst req", {31'd0, data_in_req}, 0);
    chk("post rst busy", {31'd0, busy}, 0);
    sb.delete();
    @(negedge clk);
    send_pkt(2'd1, 2, 1'b1, 1'b0, none);
    drain();

    ack_mode = 1;
    for (int i = 0; i < 25; i++)
      send_pkt(2'($urandom_range(0, 3)), $urandom_range(1, 63),
               1'($urandom_range(0, 1)), 1'b1, none);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
